// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: control codes, FSM states, bus width.
// Optional perf counters in pipe_ctrl_unit are enabled by defining PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

    localparam int CTRL_W = 2;

    localparam logic [CTRL_W-1:0] CTRL_DEFAULT = 2'b00;
    localparam logic [CTRL_W-1:0] CTRL_BLOCK   = 2'b01;
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE  = 2'b10;
    localparam logic [CTRL_W-1:0] CTRL_BRANCH  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_STALL      = 2'd1,
        ST_STALL_PEND = 2'd2,
        ST_FLUSH      = 2'd3
    } pc_state_t;

endpackage

// File: rtl/pipe_ctrl_stage_dec.sv
// Per-stage control-code decoder shared by the stall and redirect patterns.
// Bubble range [bubble_lo, bubble_hi] is inclusive; lo > hi means no bubble.
module pipe_ctrl_stage_dec
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 6,
    parameter int IDX_W      = $clog2(NUM_STAGES)
) (
    input  logic                           block_en,
    input  logic [IDX_W-1:0]               b_lvl,
    input  logic [IDX_W-1:0]               bubble_lo,
    input  logic [IDX_W-1:0]               bubble_hi,
    input  logic                           branch_en,
    output logic [NUM_STAGES*CTRL_W-1:0]   ctrl_o
);

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        logic w_blk;
        logic w_bub;
        logic w_brn;

        assign w_brn = branch_en && (s == 0);
        assign w_blk = block_en && (s <= int'(b_lvl));
        assign w_bub = (s >= int'(bubble_lo)) && (s <= int'(bubble_hi));

        assign ctrl_o[s*CTRL_W +: CTRL_W] = w_brn ? CTRL_BRANCH :
                                            w_blk ? CTRL_BLOCK  :
                                            w_bub ? CTRL_BUBBLE : CTRL_DEFAULT;
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Parametrised stall/redirect controller; redirects arriving mid-stall are held until release.
// Define PIPE_CTRL_PERF_EN to add saturating stall/redirect performance counters.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 6,
    parameter int NUM_SRC    = 3,
    parameter int ADDR_W     = 64,
    parameter int FLUSH_HOLD = 1,
    parameter int IDX_W      = $clog2(NUM_STAGES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            stall_req_i,
    input  logic [NUM_SRC*IDX_W-1:0]      stall_stage_i,
    input  logic                          redir_valid_i,
    input  logic [ADDR_W-1:0]             redir_pc_i,
    input  logic [IDX_W-1:0]              redir_stage_i,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]                   perf_stall_cyc_o,
    output logic [31:0]                   perf_redir_cnt_o,
    output logic [31:0]                   perf_redir_drop_o,
`endif
    output logic [NUM_STAGES*CTRL_W-1:0]  ctrl_signal_o,
    output logic [ADDR_W-1:0]             ctrl_to_pc_new_o,
    output logic                          stall_active_o
);

    pc_state_t         r_state, w_nstate;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_pend_pc;
    logic [IDX_W-1:0]  r_pend_stage;

    logic              w_any_req;
    logic [IDX_W-1:0]  w_blvl, w_sidx, w_rstage;
    logic [IDX_W-1:0]  w_bub_lo, w_bub_hi, w_dec_lvl;
    logic              w_block_en, w_brn_en, w_pend_ld, w_use_pend, w_drop;

    // Stall level: highest (saturated) stage among asserted requesters
    always_comb begin
        w_any_req = |stall_req_i;
        w_blvl    = '0;
        w_sidx    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (stall_req_i[k]) begin
                w_sidx = stall_stage_i[k*IDX_W +: IDX_W];
                if (int'(w_sidx) > NUM_STAGES-1) w_sidx = IDX_W'(NUM_STAGES-1);
                if (w_sidx > w_blvl) w_blvl = w_sidx;
            end
        end
    end

    always_comb begin
        w_nstate   = r_state;
        w_cnt_nxt  = r_cnt;
        w_pend_ld  = 1'b0;
        w_block_en = 1'b0;
        w_brn_en   = 1'b0;
        w_use_pend = 1'b0;
        w_drop     = 1'b0;
        unique case (r_state)
            ST_RUN, ST_STALL: begin
                if (w_any_req) begin
                    w_block_en = 1'b1;
                    w_nstate   = ST_STALL;
                    if (redir_valid_i) begin
                        w_pend_ld = 1'b1;
                        w_nstate  = ST_STALL_PEND;
                    end
                end else if (redir_valid_i) begin
                    w_brn_en  = 1'b1;
                    w_cnt_nxt = 4'(FLUSH_HOLD);
                    w_nstate  = ST_FLUSH;
                end else begin
                    w_nstate = ST_RUN;
                end
            end
            ST_STALL_PEND: begin
                w_use_pend = 1'b1;
                w_drop     = redir_valid_i;
                if (w_any_req) begin
                    w_block_en = 1'b1;
                end else begin
                    w_brn_en  = 1'b1;
                    w_cnt_nxt = 4'(FLUSH_HOLD);
                    w_nstate  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_drop = redir_valid_i;
                if (w_any_req) begin
                    w_block_en = 1'b1;
                end else if (r_cnt <= 4'd1) begin
                    w_cnt_nxt = '0;
                    w_nstate  = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_nstate = ST_RUN;
        endcase
    end

    assign w_rstage = w_use_pend ? r_pend_stage : redir_stage_i;

    // Bubble range: one stage past the frozen region, or stages 1..R-1 on redirect
    always_comb begin
        w_bub_lo = IDX_W'(1);
        w_bub_hi = '0;
        if (rst) begin
            w_bub_lo = IDX_W'(1);
        end else if (w_block_en) begin
            if (int'(w_blvl) < NUM_STAGES-1) begin
                w_bub_lo = w_blvl + IDX_W'(1);
                w_bub_hi = w_blvl + IDX_W'(1);
            end
        end else if (w_brn_en && (w_rstage != '0)) begin
            w_bub_hi = w_rstage - IDX_W'(1);
        end
    end

    assign w_dec_lvl = rst ? IDX_W'(NUM_STAGES-1) : w_blvl;

    pipe_ctrl_stage_dec #(
        .NUM_STAGES (NUM_STAGES),
        .IDX_W      (IDX_W)
    ) u_dec (
        .block_en  (rst | w_block_en),
        .b_lvl     (w_dec_lvl),
        .bubble_lo (w_bub_lo),
        .bubble_hi (w_bub_hi),
        .branch_en (~rst & w_brn_en),
        .ctrl_o    (ctrl_signal_o)
    );

    assign ctrl_to_pc_new_o = rst ? '0 : (w_use_pend ? r_pend_pc : redir_pc_i);
    assign stall_active_o   = rst | w_block_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_cnt        <= '0;
            r_pend_pc    <= '0;
            r_pend_stage <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_cnt_nxt;
            if (w_pend_ld) begin
                r_pend_pc    <= redir_pc_i;
                r_pend_stage <= redir_stage_i;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cyc_o  <= '0;
            perf_redir_cnt_o  <= '0;
            perf_redir_drop_o <= '0;
        end else begin
            if (w_block_en && (perf_stall_cyc_o != '1))  perf_stall_cyc_o  <= perf_stall_cyc_o + 32'd1;
            if (w_brn_en && (perf_redir_cnt_o != '1))    perf_redir_cnt_o  <= perf_redir_cnt_o + 32'd1;
            if (w_drop && (perf_redir_drop_o != '1))     perf_redir_drop_o <= perf_redir_drop_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed, table-driven bench for pipe_ctrl_unit (6 stages, 3 sources, FLUSH_HOLD=1).
module tb_pipe_ctrl_unit;

    localparam int NS = 6;
    localparam int NSRC = 3;
    localparam int AW = 64;
    localparam int IW = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NSRC-1:0]      stall_req_i;
    logic [NSRC*IW-1:0]   stall_stage_i;
    logic                 redir_valid_i;
    logic [AW-1:0]        redir_pc_i;
    logic [IW-1:0]        redir_stage_i;
    logic [NS*2-1:0]      ctrl_signal_o;
    logic [AW-1:0]        ctrl_to_pc_new_o;
    logic                 stall_active_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]          perf_stall_cyc_o, perf_redir_cnt_o, perf_redir_drop_o;
`endif

    always #5 clk = ~clk;

    pipe_ctrl_unit #(
        .NUM_STAGES (NS),
        .NUM_SRC    (NSRC),
        .ADDR_W     (AW),
        .FLUSH_HOLD (1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_req_i      (stall_req_i),
        .stall_stage_i    (stall_stage_i),
        .redir_valid_i    (redir_valid_i),
        .redir_pc_i       (redir_pc_i),
        .redir_stage_i    (redir_stage_i),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cyc_o  (perf_stall_cyc_o),
        .perf_redir_cnt_o  (perf_redir_cnt_o),
        .perf_redir_drop_o (perf_redir_drop_o),
`endif
        .ctrl_signal_o    (ctrl_signal_o),
        .ctrl_to_pc_new_o (ctrl_to_pc_new_o),
        .stall_active_o   (stall_active_o)
    );

    typedef struct {
        logic [2:0]  req;
        logic [8:0]  stg;
        logic        rv;
        logic [63:0] pc;
        logic [2:0]  rs;
        logic [11:0] ectrl;
        logic [63:0] epc;
        logic        eact;
    } vec_t;

    vec_t tv[21];
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] req, input logic [8:0] stg, input logic rv,
                                input logic [63:0] pc, input logic [2:0] rs, input logic [11:0] ectrl,
                                input logic [63:0] epc, input logic eact);
        vec_t v;
        v.req = req; v.stg = stg; v.rv = rv; v.pc = pc; v.rs = rs;
        v.ectrl = ectrl; v.epc = epc; v.eact = eact;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        stall_req_i   = v.req;
        stall_stage_i = v.stg;
        redir_valid_i = v.rv;
        redir_pc_i    = v.pc;
        redir_stage_i = v.rs;
    endtask

    initial begin
        int exp_stall, exp_redir;
        exp_stall = 0;
        exp_redir = 0;
        // stage codes packed stage5..stage0; stall_stage_i slice k = bits [3k+2:3k]
        tv[0]  = mk(3'b000, 9'h000, 0, 64'h0,        3'd0, 12'h000, 64'h0,        0);
        tv[1]  = mk(3'b010, 9'h018, 0, 64'h0,        3'd0, 12'h255, 64'h0,        1);
        tv[2]  = mk(3'b011, 9'h021, 0, 64'h0,        3'd0, 12'h955, 64'h0,        1);
        tv[3]  = mk(3'b010, 9'h021, 0, 64'h0,        3'd0, 12'h955, 64'h0,        1);
        tv[4]  = mk(3'b000, 9'h000, 0, 64'h0,        3'd0, 12'h000, 64'h0,        0);
        tv[5]  = mk(3'b000, 9'h000, 1, 64'h80000040, 3'd3, 12'h02B, 64'h80000040, 0);
        tv[6]  = mk(3'b000, 9'h000, 1, 64'h1234,     3'd4, 12'h000, 64'h1234,     0);
        tv[7]  = mk(3'b000, 9'h000, 0, 64'h0,        3'd0, 12'h000, 64'h0,        0);
        tv[8]  = mk(3'b100, 9'h1C0, 1, 64'h1000,     3'd4, 12'h555, 64'h1000,     1);
        tv[9]  = mk(3'b100, 9'h1C0, 0, 64'hDEAD,     3'd0, 12'h555, 64'h1000,     1);
        tv[10] = mk(3'b100, 9'h1C0, 1, 64'h2222,     3'd1, 12'h555, 64'h1000,     1);
        tv[11] = mk(3'b100, 9'h1C0, 0, 64'h0,        3'd0, 12'h555, 64'h1000,     1);
        tv[12] = mk(3'b000, 9'h000, 0, 64'h0,        3'd0, 12'h0AB, 64'h1000,     0);
        tv[13] = mk(3'b001, 9'h000, 1, 64'h3,        3'd2, 12'h009, 64'h3,        1);
        tv[14] = mk(3'b000, 9'h000, 0, 64'h0,        3'd0, 12'h000, 64'h0,        0);
        tv[15] = mk(3'b000, 9'h000, 1, 64'h40,       3'd1, 12'h003, 64'h40,       0);
        tv[16] = mk(3'b000, 9'h000, 0, 64'h0,        3'd0, 12'h000, 64'h0,        0);
        tv[17] = mk(3'b001, 9'h001, 0, 64'h0,        3'd0, 12'h025, 64'h0,        1);
        tv[18] = mk(3'b001, 9'h001, 1, 64'h5550,     3'd3, 12'h025, 64'h5550,     1);
        tv[19] = mk(3'b000, 9'h000, 0, 64'h0,        3'd0, 12'h02B, 64'h5550,     0);
        tv[20] = mk(3'b000, 9'h000, 0, 64'h0,        3'd0, 12'h000, 64'h0,        0);

        rst = 1'b1;
        stall_req_i = '0; stall_stage_i = '0; redir_valid_i = 1'b1;
        redir_pc_i = 64'hABCD; redir_stage_i = 3'd2;
        @(negedge clk);
        chk("reset_ctrl", 64'(ctrl_signal_o), 64'h555);
        chk("reset_pc", ctrl_to_pc_new_o, 64'h0);
        chk("reset_active", 64'(stall_active_o), 64'h1);

        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 21; i++) begin
            drive(tv[i]);
            @(negedge clk);
            chk($sformatf("v%0d_ctrl", i), 64'(ctrl_signal_o), 64'(tv[i].ectrl));
            chk($sformatf("v%0d_pc", i), ctrl_to_pc_new_o, tv[i].epc);
            chk($sformatf("v%0d_active", i), 64'(stall_active_o), 64'(tv[i].eact));
            if (tv[i].eact) exp_stall++;
            if (tv[i].ectrl[1:0] == 2'b11) exp_redir++;
            @(posedge clk); #1;
        end

`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall", perf_stall_cyc_o, 64'(exp_stall));
        chk("perf_redir", perf_redir_cnt_o, 64'(exp_redir));
        chk("perf_drop", perf_redir_drop_o, 64'd3);
`endif

        // Reset while a redirect is pending: it must be discarded
        stall_req_i = 3'b100; stall_stage_i = 9'h1C0;
        redir_valid_i = 1'b1; redir_pc_i = 64'h7777; redir_stage_i = 3'd2;
        @(posedge clk); #1;
        redir_valid_i = 1'b0;
        @(negedge clk);
        chk("pend_ctrl", 64'(ctrl_signal_o), 64'h555);
        chk("pend_pc", ctrl_to_pc_new_o, 64'h7777);
        rst = 1'b1;
        #1;
        chk("midrst_ctrl", 64'(ctrl_signal_o), 64'h555);
        chk("midrst_pc", ctrl_to_pc_new_o, 64'h0);
        chk("midrst_active", 64'(stall_active_o), 64'h1);
        stall_req_i = '0; stall_stage_i = '0; redir_pc_i = '0; redir_stage_i = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d_ctrl", i), 64'(ctrl_signal_o), 64'h000);
            chk($sformatf("postrst%0d_active", i), 64'(stall_active_o), 64'h0);
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Parametrised pipeline hazard controller. It generalises the fixed five-stage stall/branch controller to `NUM_STAGES` stages and `NUM_SRC` independent stall requesters, each naming the stage it originates from. It places bubbles only downstream of the frozen region, and holds a redirect that arrives during a stall until the stall releases, instead of dropping it. It sits between the hazard sources (caches, memory stage, execute/branch) and the per-stage pipeline registers, including PC as stage 0.

## Interface
Parameters:
- `NUM_STAGES`, 6: number of controlled stages; index 0 = PC, last index = MEM_WB.
- `NUM_SRC`, 3: number of stall requesters.
- `ADDR_W`, 64: redirect address width.
- `FLUSH_HOLD`, 1: number of cycles after a redirect during which further redirects are ignored; legal range 1..15.
- `IDX_W`, `$clog2(NUM_STAGES)`: width of a stage index.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: async reset, active-high.
- `stall_req_i` in `NUM_SRC`: level stall request, one bit per source.
- `stall_stage_i` in `NUM_SRC*IDX_W`: stage index owned by each source; slice k belongs to source k.
- `redir_valid_i` in 1: redirect request, one-cycle pulse.
- `redir_pc_i` in `ADDR_W`: redirect target.
- `redir_stage_i` in `IDX_W`: stage that produced the redirect; must be ≥1.
- `ctrl_signal_o` out `NUM_STAGES*2`: per-stage control code; slice s drives stage s.
- `ctrl_to_pc_new_o` out `ADDR_W`: redirect target presented to PC.
- `stall_active_o` out 1: high whenever any stage is Block.

## Operation
- Control codes: Default 00, Block 01, Bubble 10, Branch 11. Branch is legal only on stage 0.
- Stall level B = the maximum `stall_stage_i` over all asserted requesters. When any request is asserted:
  - stages 0..B = Block;
  - stage B+1 = Bubble, if B+1 < `NUM_STAGES`;
  - stages above B+1 = Default.
- Redirect applied with redirect stage R:
  - stage 0 = Branch;
  - stages 1..R-1 = Bubble;
  - stages R and above = Default;
  - `ctrl_to_pc_new_o` = target.
- FSM states: RUN, STALL, STALL_PEND, FLUSH.
  - RUN: stall request → STALL and outputs stall pattern (stall has priority). If `redir_valid_i` arrives in the same cycle, capture `redir_pc_i`/`redir_stage_i` → STALL_PEND. Redirect only → apply redirect, load flush counter with `FLUSH_HOLD` → FLUSH.
  - STALL: stall pattern each cycle. `redir_valid_i` → capture → STALL_PEND. All requests low → RUN, with Default outputs that cycle.
  - STALL_PEND: stall pattern; further `redir_valid_i` ignored. All requests low → apply captured redirect that cycle → FLUSH.
  - FLUSH: `redir_valid_i` ignored; counter decrements each non-stalled cycle; outputs Default. Counter reaches 0 → RUN. A stall in FLUSH outputs the stall pattern and freezes the counter; the state stays FLUSH.
- `ctrl_to_pc_new_o` = captured register in STALL_PEND and on the release cycle; otherwise = `redir_pc_i` passthrough.
- `stall_stage_i` values ≥ `NUM_STAGES` saturate to `NUM_STAGES-1`.

## Timing
- Outputs are combinational from registered state plus current inputs: zero-cycle response to a request.
- State, pending register and flush counter update on the rising edge of `clk`.
- While `rst` is high: state = RUN, counter = 0, pending register cleared, all `ctrl_signal_o` = Block, `ctrl_to_pc_new_o` = 0, `stall_active_o` = 1.
- First cycle after `rst` falls, with idle inputs: all stages Default.
- `rst` asserted mid-stall or mid-pending discards the pending redirect.
- Pending redirect latency: it is applied in exactly the cycle the last stall request drops.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: adds 32-bit saturating counters:
  - `perf_stall_cyc_o`: cycles with `stall_active_o` high;
  - `perf_redir_cnt_o`: redirects applied;
  - `perf_redir_drop_o`: redirects ignored in FLUSH or STALL_PEND.
  - All three reset to 0.
- Macro undefined: those ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package/defines hold:
  - control-code constants;
  - FSM state encodings (RUN 0, STALL 1, STALL_PEND 2, FLUSH 3);
  - the ctrl-bus width (2).
- One sub-module, `pipe_ctrl_stage_dec`. It is combinational, with inputs (block_en, B, bubble_lo, bubble_hi, branch_en) and output `NUM_STAGES*2`. It builds the per-stage vector for both the stall and redirect patterns.

## Test plan
- Source 1 requests with stage 3, `NUM_STAGES`=6 → `ctrl_signal_o` stages 0–3 = 01, stage 4 = 10, stage 5 = 00; `stall_active_o`=1.
- Two sources request with stages 1 and 4 → B=4: stages 0–4 = 01, stage 5 = 10. Drop source 1 only → unchanged. Drop both → all 00.
- Redirect to 0x8000_0040 with R=3 while in RUN → same cycle stage 0 = 11, stages 1–2 = 10, stages 3–5 = 00, `ctrl_to_pc_new_o`=0x8000_0040. Next cycle's redirect is ignored with `FLUSH_HOLD`=1.
- Stall at stage 4 plus simultaneous redirect to 0x1000 → 3 stall cycles hold Block with no Branch. Release cycle: stage 0 = 11, PC target 0x1000.
- Assert `rst` during STALL_PEND → outputs all 01. After reset, no Branch appears when requests are idle.
- `PIPE_CTRL_PERF_EN`: 5 stall cycles and 2 applied redirects → `perf_stall_cyc_o`=5, `perf_redir_cnt_o`=2.
